// File: rtl/ram_seq_pkg.sv
// Shared constants, FSM encoding and register-bank address helper for the RAM access sequencer.
package ram_seq_pkg;

  localparam logic [1:0] MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MODE_INDIRECT = 2'd1;
  localparam logic [1:0] MODE_REGISTER = 2'd2;
  localparam logic [1:0] MODE_BIT      = 2'd3;

  localparam logic [7:0] BIT_AREA_BASE = 8'h20;
  localparam logic [7:0] SFR_BIT_MASK  = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PTR_RD    = 3'd1,
    ST_PTR_WAIT  = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_DATA_WAIT = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  // Rn and the @Ri pointers live in the 8-byte bank selected by PSW.RS.
  function automatic logic [7:0] reg_addr(input logic [1:0] rs, input logic [2:0] idx);
    return {3'b000, rs, idx};
  endfunction

endpackage

// File: rtl/bit_addr_map.sv
// Maps an 8051 bit address to the RAM byte holding it and the bit selector the RAM expects.
module bit_addr_map
  import ram_seq_pkg::*;
(
  input  logic [7:0] bit_i,
  output logic [7:0] byte_addr_o,
  output logic [7:0] bit_addr_o
);

  // Low half addresses the 0x20..0x2F bit area; high half addresses bit-capable SFRs.
  always_comb begin
    if (!bit_i[7]) begin
      byte_addr_o = BIT_AREA_BASE + {3'b000, bit_i[7:3]};
      bit_addr_o  = bit_i;
    end else begin
      byte_addr_o = bit_i & SFR_BIT_MASK;
      bit_addr_o  = {5'b00000, bit_i[2:0]};
    end
  end

endmodule

// File: rtl/ram_access_sequencer.sv
// Turns one execute-stage operand request into memory_ram rd/wr pulses and returns the result
// over a valid/ready response channel; one request in flight at a time.
module ram_access_sequencer
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_mode_i,
  input  logic              req_write_i,
  input  logic [7:0]        req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              req_wbit_i,
  input  logic [1:0]        psw_rs_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rd_o,
  output logic              ram_wr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_wbit_o,
  output logic [7:0]        ram_bit_addr_o,
  output logic              ram_is_bit_o,
  output logic              ram_indirect_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_rbit_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_bit_o
);

  state_t            state_q;
  logic [1:0]        mode_q;
  logic              write_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_rd_q;
  logic              ram_wr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_wbit_q;
  logic [7:0]        ram_bit_addr_q;
  logic              ram_is_bit_q;
  logic              ram_indirect_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_bit_q;

  logic [7:0] bit_byte_addr;
  logic [7:0] bit_sel_addr;
  logic [7:0] res_addr;
  logic [7:0] res_bit_addr;

  bit_addr_map u_bit_addr_map (
    .bit_i       (req_addr_i),
    .byte_addr_o (bit_byte_addr),
    .bit_addr_o  (bit_sel_addr)
  );

  // Resolved from the live request so the first pulse can issue the cycle after acceptance.
  always_comb begin
    res_addr     = req_addr_i;
    res_bit_addr = 8'h00;
    case (req_mode_i)
      MODE_DIRECT:   res_addr = req_addr_i;
      MODE_REGISTER: res_addr = reg_addr(psw_rs_i, req_addr_i[2:0]);
      MODE_INDIRECT: res_addr = reg_addr(psw_rs_i, {2'b00, req_addr_i[0]});
      MODE_BIT: begin
        res_addr     = bit_byte_addr;
        res_bit_addr = bit_sel_addr;
      end
      default: res_addr = req_addr_i;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_DIRECT;
      write_q        <= 1'b0;
      ram_addr_q     <= '0;
      ram_rd_q       <= 1'b0;
      ram_wr_q       <= 1'b0;
      ram_wdata_q    <= '0;
      ram_wbit_q     <= 1'b0;
      ram_bit_addr_q <= 8'h00;
      ram_is_bit_q   <= 1'b0;
      ram_indirect_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_bit_q      <= 1'b0;
    end else begin
      ram_rd_q       <= 1'b0;
      ram_wr_q       <= 1'b0;
      ram_is_bit_q   <= 1'b0;
      ram_indirect_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            mode_q         <= req_mode_i;
            write_q        <= req_write_i;
            ram_addr_q     <= res_addr;
            ram_bit_addr_q <= res_bit_addr;
            ram_wdata_q    <= req_wdata_i;
            ram_wbit_q     <= req_wbit_i;
            if (req_mode_i == MODE_INDIRECT) begin
              ram_rd_q <= 1'b1;
              state_q  <= ST_PTR_RD;
            end else begin
              ram_rd_q     <= !req_write_i;
              ram_wr_q     <= req_write_i;
              ram_is_bit_q <= (req_mode_i == MODE_BIT);
              state_q      <= ST_ACCESS;
            end
          end
        end
        ST_PTR_RD: state_q <= ST_PTR_WAIT;
        ST_PTR_WAIT: begin
          // The address register doubles as the pointer register for the access pulse.
          ram_addr_q     <= ram_rdata_i;
          ram_indirect_q <= 1'b1;
          ram_rd_q       <= !write_q;
          ram_wr_q       <= write_q;
          state_q        <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (write_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_bit_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_DATA_WAIT;
          end
        end
        ST_DATA_WAIT: begin
          rsp_valid_q <= 1'b1;
          if (mode_q == MODE_BIT) begin
            rsp_data_q <= '0;
            rsp_bit_q  <= ram_rbit_i;
          end else begin
            rsp_data_q <= ram_rdata_i;
            rsp_bit_q  <= 1'b0;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o    = (state_q == ST_IDLE);
  assign ram_addr_o     = ram_addr_q;
  assign ram_rd_o       = ram_rd_q;
  assign ram_wr_o       = ram_wr_q;
  assign ram_wdata_o    = ram_wdata_q;
  assign ram_wbit_o     = ram_wbit_q;
  assign ram_bit_addr_o = ram_bit_addr_q;
  assign ram_is_bit_o   = ram_is_bit_q;
  assign ram_indirect_o = ram_indirect_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_bit_o      = rsp_bit_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer with a behavioural 8051-style IRAM/SFR memory behind it.
module tb_ram_access_sequencer;
  import ram_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_valid, req_ready, req_write, req_wbit;
  logic [1:0] req_mode, psw_rs;
  logic [7:0] req_addr, req_wdata;
  logic [7:0] ram_addr, ram_wdata, ram_bit_addr, mem_out, rsp_data;
  logic       ram_rd, ram_wr, ram_wbit, ram_is_bit, ram_indirect, mem_out_bit;
  logic       rsp_valid, rsp_ready, rsp_bit;

  ram_access_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_mode_i(req_mode),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wbit_i(req_wbit), .psw_rs_i(psw_rs),
    .ram_addr_o(ram_addr), .ram_rd_o(ram_rd), .ram_wr_o(ram_wr),
    .ram_wdata_o(ram_wdata), .ram_wbit_o(ram_wbit), .ram_bit_addr_o(ram_bit_addr),
    .ram_is_bit_o(ram_is_bit), .ram_indirect_o(ram_indirect),
    .ram_rdata_i(mem_out), .ram_rbit_i(mem_out_bit),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_bit_o(rsp_bit)
  );

  // Memory model: direct >=0x80 hits SFRs, indirect always hits IRAM; output lags rd by one cycle.
  logic [7:0] iram [0:255];
  logic [7:0] sfr  [0:255];
  logic       pl_en, pl_sfr;
  logic [7:0] pl_addr, pl_data, rd_byte;

  assign rd_byte = (ram_addr[7] && !ram_indirect) ? sfr[ram_addr] : iram[ram_addr];

  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_sfr) sfr[pl_addr] <= pl_data;
      else        iram[pl_addr] <= pl_data;
    end
    if (ram_wr) begin
      if (ram_is_bit) begin
        if (ram_addr[7]) sfr[ram_addr][ram_bit_addr[2:0]] <= ram_wbit;
        else             iram[ram_addr][ram_bit_addr[2:0]] <= ram_wbit;
      end else if (ram_addr[7] && !ram_indirect) begin
        sfr[ram_addr] <= ram_wdata;
      end else begin
        iram[ram_addr] <= ram_wdata;
      end
    end
    if (ram_rd) begin
      mem_out     <= rd_byte;
      mem_out_bit <= rd_byte[ram_bit_addr[2:0]];
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic       b;
  } exp_t;
  exp_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  logic       tr_rd [0:15], tr_wr [0:15], tr_bit [0:15], tr_ind [0:15], tr_rv [0:15], tr_rbit [0:15];
  logic [7:0] tr_addr [0:15], tr_baddr [0:15], tr_wdata [0:15], tr_rdata [0:15];

  task automatic preload(input logic is_sfr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_sfr = is_sfr; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Leaves the bench 1 time unit into cycle 1 (acceptance edge closes cycle 0).
  task automatic send_req(input logic [1:0] mode, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic wb, input logic [1:0] rs);
    logic ok;
    ok = 1'b0;
    req_mode = mode; req_write = wr; req_addr = a; req_wdata = wd; req_wbit = wb; psw_rs = rs;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL req_accept_timeout: req_ready=%b, required 1 within 50 cycles", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic trace(input int n);
    for (int i = 0; i < 16; i++) begin
      tr_rd[i] = 1'b0; tr_wr[i] = 1'b0; tr_bit[i] = 1'b0; tr_ind[i] = 1'b0; tr_rv[i] = 1'b0;
      tr_rbit[i] = 1'b0; tr_addr[i] = 8'h00; tr_baddr[i] = 8'h00; tr_wdata[i] = 8'h00; tr_rdata[i] = 8'h00;
    end
    for (int c = 1; c <= n && c < 16; c++) begin
      @(negedge clk);
      tr_rd[c] = ram_rd; tr_wr[c] = ram_wr; tr_bit[c] = ram_is_bit; tr_ind[c] = ram_indirect;
      tr_addr[c] = ram_addr; tr_baddr[c] = ram_bit_addr; tr_wdata[c] = ram_wdata;
      tr_rv[c] = rsp_valid; tr_rdata[c] = rsp_data; tr_rbit[c] = rsp_bit;
    end
  endtask

  function automatic int first_rsp();
    for (int i = 1; i < 16; i++) if (tr_rv[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_pulses();
    int n;
    n = 0;
    for (int i = 1; i < 16; i++) if (tr_rd[i] === 1'b1 || tr_wr[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; pl_en = 1'b0; pl_sfr = 1'b0;
    pl_addr = 8'h00; pl_data = 8'h00; req_mode = MODE_DIRECT; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; req_wbit = 1'b0; psw_rs = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_req_ready: got %b, required 1", req_ready);
    end
    tests_run++;
    if ({rsp_valid, ram_rd, ram_wr, ram_is_bit, ram_indirect} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_controls: {rsp_valid,rd,wr,is_bit,ind}=%b, required 00000",
               {rsp_valid, ram_rd, ram_wr, ram_is_bit, ram_indirect});
    end
    tests_run++;
    if ({ram_addr, ram_bit_addr, ram_wdata, rsp_data} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h bit_addr=%h wdata=%h rsp_data=%h, required all 00",
               ram_addr, ram_bit_addr, ram_wdata, rsp_data);
    end
    tests_run++;
    if ({ram_wbit, rsp_bit} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_bits: wbit=%b rsp_bit=%b, required 0 0", ram_wbit, rsp_bit);
    end
  endtask

  task automatic test_direct_read();
    exp_t e; int r;
    preload(1'b0, 8'h45, 8'hA5);
    exp_q.push_back(exp_t'{data: 8'hA5, b: 1'b0});
    send_req(MODE_DIRECT, 1'b0, 8'h45, 8'h00, 1'b0, 2'd0);
    trace(6);
    tests_run++;
    if (!(tr_rd[1] === 1'b1 && tr_addr[1] === 8'h45 && tr_ind[1] === 1'b0)) begin
      tests_failed++;
      $display("FAIL direct_rd_cycle1: rd=%b addr=%h ind=%b, required rd=1 addr=45 ind=0", tr_rd[1], tr_addr[1], tr_ind[1]);
    end
    tests_run++;
    if (count_pulses() !== 1) begin
      tests_failed++; $display("FAIL direct_pulse_count: got %0d, required 1", count_pulses());
    end
    r = first_rsp();
    tests_run++;
    if (r !== 3) begin
      tests_failed++; $display("FAIL direct_rsp_cycle: got %0d, required 3", r);
    end
    e = exp_q.pop_front();
    if (r < 1) r = 1;
    tests_run++;
    if (tr_rdata[r] !== e.data || tr_rbit[r] !== e.b) begin
      tests_failed++;
      $display("FAIL direct_rsp_data: got %h/%b, required %h/%b", tr_rdata[r], tr_rbit[r], e.data, e.b);
    end
  endtask

  task automatic test_indirect_read();
    exp_t e; int r;
    preload(1'b0, 8'h11, 8'h90);
    preload(1'b0, 8'h90, 8'h3C);
    preload(1'b1, 8'h90, 8'h77);
    exp_q.push_back(exp_t'{data: 8'h3C, b: 1'b0});
    send_req(MODE_INDIRECT, 1'b0, 8'h01, 8'h00, 1'b0, 2'd2);
    trace(8);
    tests_run++;
    if (!(tr_rd[1] === 1'b1 && tr_addr[1] === 8'h11 && tr_ind[1] === 1'b0 && tr_rd[2] === 1'b0)) begin
      tests_failed++;
      $display("FAIL indirect_ptr_rd: rd1=%b addr1=%h ind1=%b rd2=%b, required 1 11 0 0", tr_rd[1], tr_addr[1], tr_ind[1], tr_rd[2]);
    end
    tests_run++;
    if (!(tr_rd[3] === 1'b1 && tr_addr[3] === 8'h90 && tr_ind[3] === 1'b1)) begin
      tests_failed++;
      $display("FAIL indirect_access_rd: rd=%b addr=%h ind=%b, required 1 90 1", tr_rd[3], tr_addr[3], tr_ind[3]);
    end
    r = first_rsp();
    tests_run++;
    if (r !== 5) begin
      tests_failed++; $display("FAIL indirect_rsp_cycle: got %0d, required 5", r);
    end
    e = exp_q.pop_front();
    if (r < 1) r = 1;
    tests_run++;
    if (tr_rdata[r] !== e.data || tr_rbit[r] !== e.b) begin
      tests_failed++;
      $display("FAIL indirect_rsp_data: got %h/%b, required %h/%b", tr_rdata[r], tr_rbit[r], e.data, e.b);
    end
  endtask

  task automatic test_bit_ops();
    exp_t e; int r;
    preload(1'b0, 8'h21, 8'h00);
    exp_q.push_back(exp_t'{data: 8'h00, b: 1'b0});
    send_req(MODE_BIT, 1'b1, 8'h0B, 8'h00, 1'b1, 2'd0);
    trace(5);
    tests_run++;
    if (!(tr_wr[1] === 1'b1 && tr_addr[1] === 8'h21 && tr_baddr[1] === 8'h0B && tr_bit[1] === 1'b1 && tr_rd[1] === 1'b0)) begin
      tests_failed++;
      $display("FAIL bitwr_pulse: wr=%b rd=%b addr=%h bit_addr=%h is_bit=%b, required 1 0 21 0B 1",
               tr_wr[1], tr_rd[1], tr_addr[1], tr_baddr[1], tr_bit[1]);
    end
    r = first_rsp();
    e = exp_q.pop_front();
    tests_run++;
    if (r !== 2 || tr_rdata[2] !== e.data || tr_rbit[2] !== e.b) begin
      tests_failed++;
      $display("FAIL bitwr_rsp: cycle=%0d data=%h bit=%b, required cycle 2 %h %b", r, tr_rdata[2], tr_rbit[2], e.data, e.b);
    end
    exp_q.push_back(exp_t'{data: 8'h08, b: 1'b0});
    send_req(MODE_DIRECT, 1'b0, 8'h21, 8'h00, 1'b0, 2'd0);
    trace(5);
    r = first_rsp(); e = exp_q.pop_front();
    if (r < 1) r = 1;
    tests_run++;
    if (tr_rdata[r] !== e.data) begin
      tests_failed++; $display("FAIL bitwr_readback: got %h, required %h", tr_rdata[r], e.data);
    end
    exp_q.push_back(exp_t'{data: 8'h00, b: 1'b1});
    send_req(MODE_BIT, 1'b0, 8'h0B, 8'h00, 1'b0, 2'd0);
    trace(5);
    r = first_rsp(); e = exp_q.pop_front();
    if (r < 1) r = 1;
    tests_run++;
    if (tr_rdata[r] !== e.data || tr_rbit[r] !== e.b) begin
      tests_failed++; $display("FAIL bitrd_low: got %h/%b, required %h/%b", tr_rdata[r], tr_rbit[r], e.data, e.b);
    end
    preload(1'b1, 8'hD0, 8'h80);
    exp_q.push_back(exp_t'{data: 8'h00, b: 1'b1});
    send_req(MODE_BIT, 1'b0, 8'hD7, 8'h00, 1'b0, 2'd0);
    trace(5);
    tests_run++;
    if (!(tr_rd[1] === 1'b1 && tr_addr[1] === 8'hD0 && tr_baddr[1] === 8'h07 && tr_bit[1] === 1'b1)) begin
      tests_failed++;
      $display("FAIL bitrd_sfr_pulse: rd=%b addr=%h bit_addr=%h is_bit=%b, required 1 D0 07 1", tr_rd[1], tr_addr[1], tr_baddr[1], tr_bit[1]);
    end
    r = first_rsp(); e = exp_q.pop_front();
    tests_run++;
    if (r !== 3 || tr_rdata[3] !== e.data || tr_rbit[3] !== e.b) begin
      tests_failed++;
      $display("FAIL bitrd_sfr_rsp: cycle=%0d data=%h bit=%b, required cycle 3 %h %b", r, tr_rdata[3], tr_rbit[3], e.data, e.b);
    end
  endtask

  task automatic test_writes();
    exp_t e; int r;
    exp_q.push_back(exp_t'{data: 8'h00, b: 1'b0});
    send_req(MODE_REGISTER, 1'b1, 8'h05, 8'h5A, 1'b0, 2'd3);
    trace(4);
    r = first_rsp(); e = exp_q.pop_front();
    tests_run++;
    if (!(tr_wr[1] === 1'b1 && tr_addr[1] === 8'h1D && tr_wdata[1] === 8'h5A && r == 2 && tr_rdata[2] === e.data)) begin
      tests_failed++;
      $display("FAIL reg_write: wr=%b addr=%h wdata=%h rsp_cycle=%0d, required 1 1D 5A 2", tr_wr[1], tr_addr[1], tr_wdata[1], r);
    end
    exp_q.push_back(exp_t'{data: 8'h5A, b: 1'b0});
    send_req(MODE_REGISTER, 1'b0, 8'h05, 8'h00, 1'b0, 2'd3);
    trace(5);
    r = first_rsp(); e = exp_q.pop_front();
    if (r < 1) r = 1;
    tests_run++;
    if (tr_rdata[r] !== e.data) begin
      tests_failed++; $display("FAIL reg_readback: got %h, required %h", tr_rdata[r], e.data);
    end
    preload(1'b0, 8'h00, 8'hC0);
    preload(1'b1, 8'hC0, 8'h11);
    exp_q.push_back(exp_t'{data: 8'h00, b: 1'b0});
    send_req(MODE_INDIRECT, 1'b1, 8'h00, 8'h6B, 1'b0, 2'd0);
    trace(6);
    r = first_rsp(); e = exp_q.pop_front();
    tests_run++;
    if (!(tr_rd[1] === 1'b1 && tr_addr[1] === 8'h00 && tr_wr[3] === 1'b1 && tr_addr[3] === 8'hC0 &&
          tr_ind[3] === 1'b1 && tr_wdata[3] === 8'h6B && count_pulses() == 2)) begin
      tests_failed++;
      $display("FAIL ind_write_pulses: wr3=%b addr3=%h ind3=%b wdata3=%h pulses=%0d, required 1 C0 1 6B 2",
               tr_wr[3], tr_addr[3], tr_ind[3], tr_wdata[3], count_pulses());
    end
    tests_run++;
    if (r !== 4 || tr_rdata[4] !== e.data) begin
      tests_failed++; $display("FAIL ind_write_rsp: cycle=%0d data=%h, required cycle 4 %h", r, tr_rdata[4], e.data);
    end
    exp_q.push_back(exp_t'{data: 8'h6B, b: 1'b0});
    send_req(MODE_INDIRECT, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);
    trace(7);
    r = first_rsp(); e = exp_q.pop_front();
    if (r < 1) r = 1;
    tests_run++;
    if (tr_rdata[r] !== e.data) begin
      tests_failed++; $display("FAIL ind_readback: got %h, required %h", tr_rdata[r], e.data);
    end
    exp_q.push_back(exp_t'{data: 8'h11, b: 1'b0});
    send_req(MODE_DIRECT, 1'b0, 8'hC0, 8'h00, 1'b0, 2'd0);
    trace(5);
    r = first_rsp(); e = exp_q.pop_front();
    if (r < 1) r = 1;
    tests_run++;
    if (tr_rdata[r] !== e.data) begin
      tests_failed++; $display("FAIL sfr_untouched: got %h, required %h", tr_rdata[r], e.data);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2; int acc_cyc, rsp2; logic stable, rdy_low; logic [7:0] d3, d2;
    preload(1'b0, 8'h30, 8'h5C);
    preload(1'b0, 8'h31, 8'hE1);
    rsp_ready = 1'b0;
    exp_q.push_back(exp_t'{data: 8'h5C, b: 1'b0});
    exp_q.push_back(exp_t'{data: 8'hE1, b: 1'b0});
    send_req(MODE_DIRECT, 1'b0, 8'h30, 8'h00, 1'b0, 2'd0);
    req_mode = MODE_DIRECT; req_write = 1'b0; req_addr = 8'h31; req_valid = 1'b1;
    acc_cyc = -1; rsp2 = -1; stable = 1'b1; rdy_low = 1'b1; d3 = 8'h00; d2 = 8'h00;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 3) d3 = rsp_data;
      if (cyc >= 3 && cyc <= 6 && (rsp_valid !== 1'b1 || rsp_data !== d3)) stable = 1'b0;
      if (cyc <= 6 && req_ready !== 1'b0) rdy_low = 1'b0;
      if (acc_cyc < 0 && req_valid && req_ready === 1'b1) acc_cyc = cyc;
      if (acc_cyc > 0 && cyc > acc_cyc && rsp2 < 0 && rsp_valid === 1'b1) begin
        rsp2 = cyc; d2 = rsp_data;
      end
      @(posedge clk); #1;
      if (cyc == acc_cyc) req_valid = 1'b0;
      if (cyc == 5) rsp_ready = 1'b1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    tests_run++;
    if (!stable || d3 !== e1.data) begin
      tests_failed++; $display("FAIL stall_data_stable: stable=%b data=%h, required 1 %h", stable, d3, e1.data);
    end
    tests_run++;
    if (!rdy_low) begin
      tests_failed++; $display("FAIL stall_req_ready: req_ready rose before handshake, required 0 through cycle 6");
    end
    tests_run++;
    if (acc_cyc !== 7) begin
      tests_failed++; $display("FAIL next_accept_cycle: got %0d, required 7", acc_cyc);
    end
    tests_run++;
    if (rsp2 !== 10 || d2 !== e2.data) begin
      tests_failed++; $display("FAIL second_rsp: cycle=%0d data=%h, required 10 %h", rsp2, d2, e2.data);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int r; logic rd1, extra_rd, any_rv, rdy3;
    preload(1'b0, 8'h08, 8'h50);
    preload(1'b0, 8'h50, 8'h99);
    send_req(MODE_INDIRECT, 1'b0, 8'h00, 8'h00, 1'b0, 2'd1);
    @(negedge clk);
    rd1 = (ram_rd === 1'b1 && ram_addr === 8'h08);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    extra_rd = 1'b0; any_rv = 1'b0; rdy3 = 1'b0;
    for (int cyc = 3; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 3) rdy3 = (req_ready === 1'b1);
      if (ram_rd !== 1'b0 || ram_wr !== 1'b0) extra_rd = 1'b1;
      if (rsp_valid !== 1'b0) any_rv = 1'b1;
    end
    tests_run++;
    if (!rd1 || !rdy3) begin
      tests_failed++; $display("FAIL midreset_idle: ptr_rd=%b idle_at_3=%b, required 1 1", rd1, rdy3);
    end
    tests_run++;
    if (extra_rd || any_rv) begin
      tests_failed++; $display("FAIL midreset_quiet: access_pulse=%b rsp_valid_seen=%b, required 0 0", extra_rd, any_rv);
    end
    exp_q.push_back(exp_t'{data: 8'h99, b: 1'b0});
    send_req(MODE_DIRECT, 1'b0, 8'h50, 8'h00, 1'b0, 2'd0);
    trace(5);
    r = first_rsp(); e = exp_q.pop_front();
    tests_run++;
    if (r !== 3 || tr_rdata[3] !== e.data) begin
      tests_failed++; $display("FAIL post_reset_read: cycle=%0d data=%h, required 3 %h", r, tr_rdata[3], e.data);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_direct_read();
    test_indirect_read();
    test_bit_ops();
    test_writes();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
